// File: rtl/fault_inject_ram.sv
// Single-port synchronous RAM with a runtime-programmable fault table (stuck-at and
// transition-up faults), saturating access counters and a per-read fault-hit flag.
module fault_inject_ram #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int NUM_FAULTS = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csin,
    input  logic              rwbarin,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    input  logic              fi_we,
    input  logic [IDX_W-1:0]  fi_idx,
    input  logic [1:0]        fi_type,
    input  logic [ADDR_W-1:0] fi_addr,
    input  logic [BIT_W-1:0]  fi_bit,
    input  logic              fi_clear_all,
    output logic              fault_hit,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [1:0] FT_NONE = 2'b00;
    localparam logic [1:0] FT_SA0  = 2'b01;
    localparam logic [1:0] FT_SA1  = 2'b10;
    localparam logic [1:0] FT_TFUP = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [NUM_FAULTS-1:0][1:0]        ftype_q, ftype_d;
    logic [NUM_FAULTS-1:0][ADDR_W-1:0] faddr_q, faddr_d;
    logic [NUM_FAULTS-1:0][BIT_W-1:0]  fbit_q, fbit_d;

    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              fault_hit_q, fault_hit_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic [DATA_W-1:0][1:0] bit_fault;
    logic                   sa_hit;
    logic [DATA_W-1:0]      raw_word, rd_word, wr_word;
    logic                   mem_we;

    // Walk entries from highest to lowest index so the lowest matching index wins per bit.
    always_comb begin
        bit_fault = '0;
        sa_hit    = 1'b0;
        for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
            if (ftype_q[i] != FT_NONE && faddr_q[i] == address) begin
                bit_fault[fbit_q[i]] = ftype_q[i];
                if (ftype_q[i] == FT_SA0 || ftype_q[i] == FT_SA1) begin
                    sa_hit = 1'b1;
                end
            end
        end
    end

    assign raw_word = mem_q[address];

    // Stuck-at faults only mask the read path; TF-up only masks the write path.
    always_comb begin
        rd_word = raw_word;
        wr_word = datain;
        for (int b = 0; b < DATA_W; b++) begin
            case (bit_fault[b])
                FT_SA0:  rd_word[b] = 1'b0;
                FT_SA1:  rd_word[b] = 1'b1;
                FT_TFUP: if (!raw_word[b]) wr_word[b] = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        dataout_d   = dataout_q;
        fault_hit_d = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        mem_we      = 1'b0;
        if (csin) begin
            if (rwbarin) begin
                dataout_d   = rd_word;
                fault_hit_d = sa_hit;
                rd_count_d  = sat_inc(rd_count_q);
            end else begin
                wr_count_d  = sat_inc(wr_count_q);
                mem_we      = !rst;
            end
        end
    end

    always_comb begin
        ftype_d = ftype_q;
        faddr_d = faddr_q;
        fbit_d  = fbit_q;
        if (fi_clear_all) begin
            ftype_d = '0;
        end else if (fi_we) begin
            ftype_d[fi_idx] = fi_type;
            faddr_d[fi_idx] = fi_addr;
            fbit_d[fi_idx]  = fi_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_q   <= '0;
            fault_hit_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            ftype_q     <= '0;
        end else begin
            dataout_q   <= dataout_d;
            fault_hit_q <= fault_hit_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            ftype_q     <= ftype_d;
        end
    end

    // Array contents and entry locations are deliberately left out of reset.
    always_ff @(posedge clk) begin
        faddr_q <= faddr_d;
        fbit_q  <= fbit_d;
        if (mem_we) begin
            mem_q[address] <= wr_word;
        end
    end

    assign dataout   = dataout_q;
    assign fault_hit = fault_hit_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_fault_inject_ram.sv
// Bench for fault_inject_ram: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_fault_inject_ram;

    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csin = 1'b0;
    logic       rwbarin = 1'b0;
    logic [5:0] address = '0;
    logic [7:0] datain = '0;
    logic [7:0] dataout;
    logic       fi_we = 1'b0;
    logic [1:0] fi_idx = '0;
    logic [1:0] fi_type = '0;
    logic [5:0] fi_addr = '0;
    logic [2:0] fi_bit = '0;
    logic       fi_clear_all = 1'b0;
    logic       fault_hit;
    logic [3:0] rd_count;
    logic [3:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    fault_inject_ram #(.ADDR_W(6), .DATA_W(8), .NUM_FAULTS(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .csin(csin), .rwbarin(rwbarin), .address(address),
        .datain(datain), .dataout(dataout), .fi_we(fi_we), .fi_idx(fi_idx),
        .fi_type(fi_type), .fi_addr(fi_addr), .fi_bit(fi_bit),
        .fi_clear_all(fi_clear_all), .fault_hit(fault_hit),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory image, fault list and expected outputs.
    logic [7:0] m_mem [64];
    int         m_ft [4];
    int         m_fa [4];
    int         m_fb [4];
    logic [7:0] m_do;
    logic       m_hit;
    int         m_rc, m_wc;
    bit         model_on = 0;

    always @(posedge clk) begin : model
        logic [7:0] w, nw;
        bit   [7:0] done;
        bit         hit;
        if (rst) begin
            m_do = 0; m_hit = 0; m_rc = 0; m_wc = 0;
            for (int i = 0; i < 4; i++) m_ft[i] = 0;
            model_on = 1;
        end else if (model_on) begin
            m_hit = 0;
            if (csin) begin
                w    = m_mem[address];
                nw   = rwbarin ? w : datain;
                done = '0;
                hit  = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m_ft[i] != 0 && m_fa[i] == int'(address)) begin
                        if (m_ft[i] == 1 || m_ft[i] == 2) hit = 1;
                        if (!done[m_fb[i]]) begin
                            done[m_fb[i]] = 1;
                            if (rwbarin && m_ft[i] == 1) nw[m_fb[i]] = 1'b0;
                            if (rwbarin && m_ft[i] == 2) nw[m_fb[i]] = 1'b1;
                            if (!rwbarin && m_ft[i] == 3 && !w[m_fb[i]]) nw[m_fb[i]] = 1'b0;
                        end
                    end
                end
                if (rwbarin) begin
                    m_do  = nw;
                    m_hit = hit;
                    m_rc  = (m_rc < CMAX) ? m_rc + 1 : m_rc;
                end else begin
                    m_mem[address] = nw;
                    m_wc = (m_wc < CMAX) ? m_wc + 1 : m_wc;
                end
            end
            if (fi_clear_all) begin
                for (int i = 0; i < 4; i++) m_ft[i] = 0;
            end else if (fi_we) begin
                m_ft[fi_idx] = int'(fi_type);
                m_fa[fi_idx] = int'(fi_addr);
                m_fb[fi_idx] = int'(fi_bit);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("cyc dataout", 32'(dataout), 32'(m_do));
            check("cyc fault_hit", 32'(fault_hit), 32'(m_hit));
            check("cyc rd_count", 32'(rd_count), 32'(m_rc));
            check("cyc wr_count", 32'(wr_count), 32'(m_wc));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        rst = 0; csin = 0; rwbarin = 0; fi_we = 0; fi_clear_all = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        csin = 1; rwbarin = 0; address = a; datain = d;
        step();
    endtask

    task automatic rd(input logic [5:0] a);
        csin = 1; rwbarin = 1; address = a; datain = 8'($urandom);
        step();
    endtask

    task automatic prog(input logic [1:0] idx, input logic [1:0] t, input logic [5:0] a,
                        input logic [2:0] b);
        fi_we = 1; fi_idx = idx; fi_type = t; fi_addr = a; fi_bit = b;
        step();
    endtask

    task automatic clrall();
        fi_clear_all = 1;
        step();
    endtask

    initial begin
        step();
        check("reset dataout", 32'(dataout), 32'h0);
        check("reset fault_hit", 32'(fault_hit), 32'h0);
        check("reset rd_count", 32'(rd_count), 32'h0);
        check("reset wr_count", 32'(wr_count), 32'h0);

        for (int a = 0; a < 64; a++) wr(6'(a), 8'($urandom));
        rst = 1;
        step();

        // Plain write/read
        wr(6'd3, 8'h5A);
        rd(6'd3);
        check("normal dataout", 32'(dataout), 32'h5A);
        check("normal fault_hit", 32'(fault_hit), 32'h0);
        check("normal wr_count", 32'(wr_count), 32'h1);
        check("normal rd_count", 32'(rd_count), 32'h1);

        // Stuck-at-1 and clear
        prog(2'd0, 2'b10, 6'd3, 3'd0);
        rd(6'd3);
        check("sa1 dataout", 32'(dataout), 32'h5B);
        check("sa1 fault_hit", 32'(fault_hit), 32'h1);
        clrall();
        rd(6'd3);
        check("sa1 cleared dataout", 32'(dataout), 32'h5A);
        check("sa1 cleared fault_hit", 32'(fault_hit), 32'h0);

        // Priority between overlapping entries
        prog(2'd1, 2'b01, 6'd10, 3'd6);
        prog(2'd2, 2'b10, 6'd10, 3'd6);
        wr(6'd10, 8'hFF);
        rd(6'd10);
        check("prio dataout", 32'(dataout), 32'hBF);
        prog(2'd1, 2'b00, 6'd10, 3'd6);
        rd(6'd10);
        check("prio disabled dataout", 32'(dataout), 32'hFF);
        clrall();

        // Transition-up fault
        prog(2'd0, 2'b11, 6'd5, 3'd2);
        wr(6'd5, 8'h00);
        wr(6'd5, 8'hFF);
        rd(6'd5);
        check("tf dataout", 32'(dataout), 32'hFB);
        check("tf fault_hit", 32'(fault_hit), 32'h0);
        clrall();
        wr(6'd5, 8'h04);
        wr(6'd5, 8'hFF);
        rd(6'd5);
        check("tf cleared dataout", 32'(dataout), 32'hFF);

        // Programming and reading in the same cycle sees the old table
        fi_we = 1; fi_idx = 2'd1; fi_type = 2'b10; fi_addr = 6'd3; fi_bit = 3'd7;
        rd(6'd3);
        check("same-cycle dataout", 32'(dataout), 32'h5A);
        check("same-cycle fault_hit", 32'(fault_hit), 32'h0);
        rd(6'd3);
        check("next-cycle dataout", 32'(dataout), 32'hDA);
        check("next-cycle fault_hit", 32'(fault_hit), 32'h1);

        // Counter saturation, then reset with an access in the reset cycle
        for (int i = 0; i < 20; i++) rd(6'd3);
        check("sat rd_count", 32'(rd_count), 32'hF);
        rst = 1; csin = 1; rwbarin = 0; address = 6'd3; datain = 8'h00;
        step();
        check("rst dataout", 32'(dataout), 32'h0);
        check("rst rd_count", 32'(rd_count), 32'h0);
        check("rst wr_count", 32'(wr_count), 32'h0);
        rd(6'd3);
        check("retained dataout", 32'(dataout), 32'h5A);
        check("retained fault_hit", 32'(fault_hit), 32'h0);

        // Randomized traffic concentrated on a few addresses so faults get exercised
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) rst = 1;
            if ($urandom_range(0, 99) < 15) begin
                fi_we   = 1;
                fi_idx  = 2'($urandom);
                fi_type = 2'($urandom);
                fi_addr = 6'($urandom_range(0, 7));
                fi_bit  = 3'($urandom);
            end
            if ($urandom_range(0, 99) < 3) fi_clear_all = 1;
            csin    = ($urandom_range(0, 99) < 70);
            rwbarin = 1'($urandom);
            address = ($urandom_range(0, 99) < 75) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            datain  = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fault_inject_ram.md
Name: fault_inject_ram

Overview:
- Single-port synchronous RAM that acts as the responder behind the memory-BIST initiator.
- Serves normal-mode and BIST-mode accesses on the same csin/rwbarin/address/datain/dataout interface the BIST drives.
- A small runtime-programmable fault table injects stuck-at and transition faults so BIST detection can be proven.
- Also counts accesses and flags every read that returns a faulted bit.

Parameters:
- ADDR_W, 6, address width (depth = 2**ADDR_W = 64 words)
- DATA_W, 8, word width
- NUM_FAULTS, 4, number of fault-table entries
- CNT_W, 16, width of the saturating access counters

Ports:
- clk  input  1  single clock, all activity on rising edge
- rst  input  1  synchronous, active-high reset
- csin  input  1  chip select, access occurs only when 1
- rwbarin  input  1  1 = read, 0 = write
- address  input  ADDR_W  word address
- datain  input  DATA_W  write data
- dataout  output  DATA_W  registered read data
- fi_we  input  1  write one fault-table entry
- fi_idx  input  clog2(NUM_FAULTS)  entry selected by fi_we
- fi_type  input  2  00 none, 01 SA0, 10 SA1, 11 TF-up (bit cannot rise 0->1)
- fi_addr  input  ADDR_W  faulty word address
- fi_bit  input  clog2(DATA_W)  faulty bit within the word
- fi_clear_all  input  1  set every entry to type 00
- fault_hit  output  1  1-cycle pulse aligned with dataout, read returned a faulted bit
- rd_count  output  CNT_W  completed reads, saturating
- wr_count  output  CNT_W  completed writes, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - dataout=0, fault_hit=0, rd_count=0, wr_count=0.
  - All fault entries set to type 00.
  - Memory array is NOT cleared; contents survive reset, including reset mid-operation. An access presented in the reset cycle is ignored.
- Write (csin=1, rwbarin=0):
  - Array word updated at the posedge; wr_count+1.
  - TF-up entry matching (address, bit) with stored bit = 0: that bit stays 0 and all other bits are written normally.
  - SA0/SA1 do not alter stored data.
- Read (csin=1, rwbarin=1):
  - Raw word is taken from the array at the posedge. dataout updates at that same edge (1-cycle latency) and rd_count+1.
  - SA0/SA1 entries matching the address force their bit in dataout only; the array is untouched, so clearing a fault restores the true data.
  - fault_hit=1 in the same cycle dataout updates, iff any SA entry matched the read address (regardless of whether the forced value differs).
- Idle (csin=0): dataout holds its last value, fault_hit=0, counters hold.
- Multiple entries on the same address/bit: the lowest index wins. Entries on different bits of the same word all apply.
- Fault-table programming:
  - An fi_we write takes effect from the next cycle; an access in the same cycle uses the old table.
  - fi_clear_all has priority over fi_we in the same cycle.
  - fi_we with fi_type=00 disables that entry.
- Counters saturate at 2**CNT_W-1 and never wrap.
- Out-of-range fi_bit values cannot occur because DATA_W is a power of two (required).

Test Plan:
- Normal access: write 0x5A to address 3, then read address 3 -> dataout=0x5A one cycle after the read edge, fault_hit=0, wr_count=1, rd_count=1.
- SA1: program idx0 = (SA1, addr 3, bit 0), read address 3 -> dataout=0x5B, fault_hit=1. Then fi_clear_all and read again -> dataout=0x5A, fault_hit=0.
- SA0 plus priority:
  - Program idx1 = (SA0, addr 10, bit 6) and idx2 = (SA1, addr 10, bit 6).
  - Write 0xFF and read -> dataout=0xBF (idx1 wins).
  - Disable idx1 and read -> 0xFF.
- TF-up at addr 5 bit 2, program idx0 = (TF-up, addr 5, bit 2):
  - Write 0x00 then 0xFF, read -> 0xFB.
  - Then clear the fault, write 0x04, write 0xFF, read -> 0xFF.
- Same-cycle program/read: assert fi_we (SA1, addr 3, bit 7) in the same cycle as a read of address 3 -> 0x5A returned, fault_hit=0. A read on the next cycle -> 0xDA.
- Saturation and reset (CNT_W=4):
  - Perform 20 reads -> rd_count=15.
  - Assert rst mid-sequence -> counters 0, faults cleared, dataout=0.
  - Read address 3 afterwards -> 0x5A, showing memory was retained.
